// File: rtl/range_sum_unit.sv
// Purpose: loop kernel computing return_val = sum of f(i), i = 0..n-1, with selectable term function.
// Latency: n+2 cycles from an accepted start to the done pulse; one term is accumulated per cycle.
// Backpressure: none; start is honoured only in IDLE, abort only in LOOP, and neither is queued.
module range_sum_unit #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     n,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] return_val,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MSB = ACC_WIDTH - 1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     i_q, i_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [1:0]           mode_q, mode_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic [ACC_WIDTH-1:0] ret_q, ret_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Term datapath signals
    logic [ACC_WIDTH-1:0] i_ext;
    logic [2*WIDTH-1:0]   i_wide;
    logic [2*WIDTH-1:0]   sq;
    logic [ACC_WIDTH-1:0] term;
    logic                 term_big;
    logic                 signed_mode;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 add_sovf;
    logic                 term_ovf;

    // Term f(i) for the registered mode, the candidate accumulate and its overflow flag
    always_comb begin
        i_ext       = ACC_WIDTH'(i_q);
        i_wide      = (2*WIDTH)'(i_q);
        sq          = i_wide * i_wide;
        term        = i_ext;
        term_big    = 1'b0;
        signed_mode = 1'b0;
        case (mode_q)
            2'b01: begin
                // Square is formed at full 2*WIDTH precision; any bit above the
                // accumulator width is a lost term and counts as overflow.
                term     = sq[ACC_WIDTH-1:0];
                term_big = ((sq >> ACC_WIDTH) != '0);
            end
            2'b10: begin
                // Alternating sign: odd indices are subtracted in two's complement.
                term        = i_q[0] ? ('0 - i_ext) : i_ext;
                signed_mode = 1'b1;
            end
            default: begin
                // Mode 11 is reserved and deliberately aliases the identity term.
                term = i_ext;
            end
        endcase
        sum_ext  = {1'b0, acc_q} + {1'b0, term};
        add_sovf = (acc_q[MSB] == term[MSB]) && (sum_ext[MSB] != acc_q[MSB]);
        term_ovf = signed_mode ? add_sovf : (sum_ext[ACC_WIDTH] | term_big);
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks loop termination
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOOP;
                end
            end
            ST_LOOP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (i_q == n_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; i is compared before it is incremented so it never wraps
    always_comb begin
        i_d       = i_q;
        n_d       = n_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        ret_d     = ret_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d       = n;
                    mode_d    = mode;
                    i_d       = '0;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            ST_LOOP: begin
                if (!abort) begin
                    if (i_q == n_q) begin
                        ret_d = acc_q;
                        ovf_d = ovf_acc_q;
                    end else begin
                        acc_d     = sum_ext[ACC_WIDTH-1:0];
                        i_d       = i_q + WIDTH'(1);
                        ovf_acc_d = ovf_acc_q | term_ovf;
                    end
                end
            end
            default: begin
                i_d = i_q;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            i_q       <= '0;
            n_q       <= '0;
            mode_q    <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            ret_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            i_q       <= i_d;
            n_q       <= n_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            ret_q     <= ret_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign return_val = ret_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_range_sum_unit.sv
// Purpose: self-checking bench for range_sum_unit against a timeline/arithmetic reference model.
// Latency: results are expected n+2 cycles after each accepted start.
// Backpressure: none; stray start/abort/reset pulses are injected to exercise the ignore rules.
module tb_range_sum_unit;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic [1:0]  mode    = 2'd0;
    logic [31:0] n       = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] return_val;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int s_cyc  = 0;

    range_sum_unit #(.WIDTH(32), .ACC_WIDTH(32)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .n          (n),
        .busy       (busy),
        .done       (done),
        .return_val (return_val),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    // Result of a full run computed directly from the term definitions
    function automatic void ref_sum(input logic [31:0] nn, input logic [1:0] md,
                                    output logic [31:0] r, output logic o);
        logic [31:0] acc;
        acc = 32'd0;
        o   = 1'b0;
        for (longint i = 0; i < longint'(nn); i++) begin
            longint t;
            longint full;
            if (md == 2'b10) begin
                t    = (i % 2 == 1) ? -i : i;
                full = longint'($signed(acc)) + t;
                if (full > 64'sd2147483647 || full < -64'sd2147483648) o = 1'b1;
            end else if (md == 2'b01) begin
                t = i * i;
                if (t > 64'sd4294967295) o = 1'b1;
                full = longint'(acc) + (t & 64'h0000_0000_FFFF_FFFF);
                if (full > 64'sd4294967295) o = 1'b1;
            end else begin
                full = longint'(acc) + i;
                if (full > 64'sd4294967295) o = 1'b1;
            end
            acc = full[31:0];
        end
        r = acc;
    endfunction

    // Reference timeline: expected outputs after every rising edge
    bit          m_valid = 1'b0;
    int          m_phase = 0;
    longint      m_left  = 0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic [31:0] m_ret   = 32'd0;
    logic        m_ovf   = 1'b0;
    logic [31:0] p_ret   = 32'd0;
    logic        p_ovf   = 1'b0;

    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_ret   = 32'd0;
            m_ovf   = 1'b0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    ref_sum(n, mode, p_ret, p_ovf);
                    m_left  = longint'(n) + 1;
                    m_phase = 1;
                    m_busy  = 1'b1;
                end
            end else if (m_phase == 1) begin
                if (abort) begin
                    m_phase = 0;
                    m_busy  = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_ret   = p_ret;
                        m_ovf   = p_ovf;
                    end
                end
            end else begin
                m_phase = 0;
                m_busy  = 1'b0;
                m_done  = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the reference timeline
    always @(negedge sys_clk) begin
        if (m_valid) begin
            check("busy", longint'(busy), longint'(m_busy));
            check("done", longint'(done), longint'(m_done));
            check("return_val", longint'(return_val), longint'(m_ret));
            check("overflow", longint'(overflow), longint'(m_ovf));
        end
    end

    // All stimulus tasks start and end 2 time units after a rising edge
    task automatic step(input int k);
        repeat (k) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic pulse_start(input logic [31:0] nv, input logic [1:0] mv);
        n     = nv;
        mode  = mv;
        start = 1'b1;
        @(posedge sys_clk);
        #1 s_cyc = cyc;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat,
                             input logic [31:0] exp_val, input logic exp_ovf);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            @(posedge sys_clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = cyc - s_cyc;
            end
            #1;
        end
        check({name, "_done_seen"}, longint'(seen), 1);
        if (seen) begin
            check({name, "_latency"}, lat, exp_lat);
            check({name, "_value"}, longint'(return_val), longint'(exp_val));
            check({name, "_ovf"}, longint'(overflow), longint'(exp_ovf));
        end
    endtask

    initial begin
        int dones;
        step(3);
        sys_rst = 1'b0;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ret", longint'(return_val), 0);
        check("rst_ovf", longint'(overflow), 0);

        pulse_start(32'd10, 2'b00);
        check("busy_after_start", longint'(busy), 1);
        wait_done("sum_i", 12, 32'd45, 1'b0);

        pulse_start(32'd10, 2'b01);
        wait_done("sum_sq", 12, 32'd285, 1'b0);
        pulse_start(32'd10, 2'b10);
        wait_done("alt", 12, 32'hFFFF_FFFB, 1'b0);

        pulse_start(32'd0, 2'b00);
        check("n0_busy_c1", longint'(busy), 1);
        wait_done("n0", 2, 32'd0, 1'b0);
        check("n0_busy_at_done", longint'(busy), 0);

        // Back-to-back: started in the cycle done is high
        pulse_start(32'd3000, 2'b01);
        wait_done("sq3000", 3002, 32'd405565908, 1'b1);
        pulse_start(32'd2000, 2'b01);
        wait_done("sq2000", 2002, 32'd2664667000, 1'b0);

        pulse_start(32'd100, 2'b00);
        step(4);
        n     = 32'd7;
        mode  = 2'b01;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done("ign_start", 102, 32'd4950, 1'b0);

        pulse_start(32'd100, 2'b00);
        step(19);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_ret", longint'(return_val), 4950);
        dones = 0;
        for (int k = 0; k < 120; k++) begin
            step(1);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        pulse_start(32'd50, 2'b00);
        step(9);
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_done", longint'(done), 0);
        check("mid_rst_ret", longint'(return_val), 0);
        check("mid_rst_ovf", longint'(overflow), 0);
        pulse_start(32'd4, 2'b11);
        wait_done("mode11", 6, 32'd6, 1'b0);

        // Randomised traffic including stray start/abort and occasional reset
        for (int c = 0; c < 4000; c++) begin
            start   = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 29) == 0);
            sys_rst = ($urandom_range(0, 599) == 0);
            n       = 32'($urandom_range(0, 40));
            mode    = 2'($urandom_range(0, 3));
            step(1);
        end
        start   = 1'b0;
        abort   = 1'b0;
        sys_rst = 1'b0;
        step(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/range_sum_unit.md
Name: range_sum_unit

Overview:
- Parametrised successor to the single-function Sum kernel.
- Computes return_val = sum over i = 0..n-1 of f(i), one term per cycle, with a selectable term function f.
- Adds features the Sum kernel lacks: start/done handshake, busy flag, abort, sticky overflow flag, and parametrised operand and accumulator widths.
- Sits as a reusable HLS-style loop kernel and is driven by a controller or testbench.

Parameters:
- WIDTH, 32, width of n and of the loop index i.
- ACC_WIDTH, 32, width of the accumulator and return_val; legal range is WIDTH..2*WIDTH.

Ports:
- sys_clk  input  1  rising-edge clock.
- sys_rst  input  1  synchronous reset, active-high.
- start  input  1  request a new run; sampled only in IDLE.
- abort  input  1  cancel the current run; acted on only in LOOP.
- mode  input  2  term function, sampled with start.
- n  input  WIDTH  iteration count, sampled with start.
- busy  output  1  high in LOOP and DONE.
- done  output  1  one-cycle pulse; return_val and overflow are valid in that cycle.
- return_val  output  ACC_WIDTH  result of the last completed run.
- overflow  output  1  sticky overflow of the last completed run.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, return_val=0, overflow=0; internal i, acc, n_reg, mode_reg cleared.
  - Reset applies from any state; a run in progress is discarded and no done pulse is produced.
- States: IDLE, LOOP, DONE.
- IDLE:
  - On start=1: capture n_reg=n and mode_reg=mode; set i=0, acc=0, ovf_acc=0; go to LOOP.
  - start in any other state is ignored; it is not queued.
- LOOP, each cycle, in priority order:
  - abort=1 -> go to IDLE. return_val and overflow keep their previous values. No done pulse.
  - i == n_reg -> go to DONE. Register return_val=acc and overflow=ovf_acc.
  - otherwise -> acc <= acc + f(i) mod 2^ACC_WIDTH; i <= i+1; ovf_acc |= term_ovf.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - A start in that following IDLE cycle is accepted normally, so back-to-back runs are allowed.
- Latency: start sampled at edge t -> LOOP occupies edges t+1..t+n+1 -> done=1 in the cycle after edge t+n+2.
  - Total is n+2 cycles from start to done.
  - n=0 gives 2 cycles and result 0.
- mode encoding:
  - 00: f(i)=i, unsigned.
  - 01: f(i)=i*i. The product is computed at 2*WIDTH bits; term_ovf=1 if the product does not fit in ACC_WIDTH, or on carry out of the accumulate.
  - 10: alternating sum. f(i)=+i for even i, -i for odd i, two's complement at ACC_WIDTH. term_ovf = signed overflow of the add (both operands the same sign, result sign different).
  - 11: reserved; behaves exactly as 00.
- Modes 00/01: term_ovf = unsigned carry out of bit ACC_WIDTH-1 of the accumulate.
- i is zero-extended to ACC_WIDTH before any add.
- n at its maximum value (2^WIDTH-1) must terminate correctly: the compare against n_reg precedes the increment, so i never wraps.
- return_val and overflow change only on DONE entry or on reset.
- done and busy are registered outputs with no combinational path from any input.

Test Plan:
- Reset, then start with n=10, mode=00 -> busy=1 on the next cycle; done pulses 12 cycles after start; return_val=45 (0x2D); overflow=0.
- Start with n=10, mode=01 -> return_val=285; done after 12 cycles. Then mode=10, n=10 -> return_val=0xFFFFFFFB (-5); overflow=0.
- Start with n=0, mode=00 -> done 2 cycles after start; return_val=0; busy high for exactly 2 cycles.
- Start with n=3000, mode=01 (ACC_WIDTH=32) -> return_val=405565908; overflow=1. Then n=2000, mode=01 -> return_val=2664667000; overflow=0.
- Start with n=100, mode=00; pulse start again at cycle 5 -> the second start is ignored, result is 4950. Next run: n=100, abort at cycle 20 -> no done pulse, return_val stays 4950, busy=0 the next cycle.
- Start with n=50; assert sys_rst at cycle 10 -> all outputs 0 the next cycle. Then start with n=4, mode=11 -> return_val=6; done pulses 6 cycles after start.
